// File: rtl/orn_accum.sv
// N-channel masked OR/NOR with a burst accumulate mode and a one-deep registered output.
// A pass beat emits one cycle after acceptance; an accumulate burst emits only on its last beat.
module orn_accum #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] x,
    input  logic [N-1:0]   ch_en,
    input  logic           inv,
    input  logic           acc,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   z,
    output logic           z_any,
    output logic [CW-1:0]  beats
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            consume;
    logic            emit;
    logic            start_burst;
    logic            add_beat;
    logic            inv_sel;
    logic            inv_l;
    logic [W-1:0]    r;
    logic [W-1:0]    t;
    logic [W-1:0]    acc_reg;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   beats_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        r = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (ch_en[k]) begin
                r = r | x[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && acc && !in_last) state_nxt = ACC;
            ACC:  if (accept && in_last)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In ACC the live inv/acc inputs are never selected, so X there cannot reach the outputs.
    always_comb begin
        start_burst = 1'b0;
        add_beat    = 1'b0;
        emit        = 1'b0;
        t           = r;
        inv_sel     = inv;
        beats_nxt   = CW'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc && !in_last) start_burst = 1'b1;
                    else                 emit        = 1'b1;
                end
            end
            ACC: begin
                t         = acc_reg | r;
                inv_sel   = inv_l;
                beats_nxt = cnt_inc;
                if (accept) begin
                    if (in_last) emit     = 1'b1;
                    else         add_beat = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_reg <= '0;
            cnt     <= '0;
            inv_l   <= 1'b0;
        end else if (start_burst) begin
            acc_reg <= r;
            cnt     <= CW'(1);
            inv_l   <= inv;
        end else if (add_beat) begin
            acc_reg <= t;
            cnt     <= cnt_inc;
        end else if (emit) begin
            acc_reg <= '0;
            cnt     <= '0;
        end
    end

    // Emit wins over consume so a result can be replaced in the same cycle without a bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            z         <= '0;
            z_any     <= 1'b0;
            beats     <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            z         <= inv_sel ? ~t : t;
            z_any     <= |t;
            beats     <= beats_nxt;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_orn_accum.sv
// Randomised and directed bench for orn_accum against a burst-level reference model.
module tb_orn_accum;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rstn;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] x;
    logic [N-1:0]   ch_en;
    logic           inv;
    logic           acc;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   z;
    logic           z_any;
    logic [CW-1:0]  beats;

    orn_accum #(.W(W), .N(N), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .ch_en     (ch_en),
        .inv       (inv),
        .acc       (acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .z_any     (z_any),
        .beats     (beats)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  z;
        logic          any;
        logic [CW-1:0] b;
    } res_t;

    res_t         q[$];
    int           n_vec = 0;
    int           n_err = 0;
    bit           m_in_burst = 1'b0;
    logic [W-1:0] m_or = '0;
    int           m_n = 0;
    bit           m_inv = 1'b0;
    bit           tk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] comb_r(input logic [N*W-1:0] xv, input logic [N-1:0] en);
        logic [W-1:0] acc_v = '0;
        for (int k = 0; k < N; k++) begin
            if (en[k]) acc_v = acc_v | xv[k*W +: W];
        end
        return acc_v;
    endfunction

    task automatic push_res(input logic [W-1:0] tv, input bit iv, input int n);
        res_t e;
        e.z   = iv ? ~tv : tv;
        e.any = |tv;
        e.b   = (n >= CMAX) ? CW'(CMAX) : CW'(n);
        q.push_back(e);
    endtask

    task automatic model_beat(input logic [W-1:0] rv, input bit iv, input bit ac, input bit lst);
        if (!m_in_burst) begin
            if (!ac || lst) begin
                push_res(rv, iv, 1);
            end else begin
                m_in_burst = 1'b1;
                m_or       = rv;
                m_n        = 1;
                m_inv      = iv;
            end
        end else begin
            m_or = m_or | rv;
            m_n++;
            if (lst) begin
                push_res(m_or, m_inv, m_n);
                m_in_burst = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_in_burst = 1'b0;
        m_or       = '0;
        m_n        = 0;
        q.delete();
    endtask

    // One clock cycle: drive, check outputs against the model queue, advance the model.
    task automatic drive(input logic v, input logic [N*W-1:0] xv, input logic [N-1:0] en,
                         input logic iv, input logic ac, input logic lst, input logic ordy,
                         output bit took);
        #2;
        in_valid  = v;
        x         = xv;
        ch_en     = en;
        inv       = iv;
        acc       = ac;
        in_last   = lst;
        out_ready = ordy;
        #1;
        check("out_valid", out_valid, q.size() != 0);
        if (out_valid && q.size() != 0) begin
            check("z", z, q[0].z);
            check("z_any", z_any, q[0].any);
            check("beats", beats, q[0].b);
        end
        check("in_ready", in_ready, !out_valid || ordy);
        took = v && in_ready;
        if (out_valid && ordy && q.size() != 0) void'(q.pop_front());
        if (took) model_beat(comb_r(xv, en), iv, ac, lst);
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy);
        bit t_unused;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, t_unused);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        ch_en     = '0;
        inv       = 1'b0;
        acc       = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #3;
        check("rst_valid", out_valid, 1'b0);
        check("rst_z", z, '0);
        check("rst_any", z_any, 1'b0);
        check("rst_beats", beats, '0);
        check("rst_ready", in_ready, 1'b1);
        #9 rstn = 1'b1;
        @(posedge clk);

        // pass mode
        drive(1'b1, {8'h08, 8'h04, 8'h02, 8'h01}, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, tk);
        #1 check("pass_z", z, 8'h0F); check("pass_any", z_any, 1'b1); check("pass_b", beats, 1);
        drive(1'b1, {8'h08, 8'h04, 8'h02, 8'h01}, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, tk);
        #1 check("nor_z", z, 8'hF0); check("nor_any", z_any, 1'b1);
        drive(1'b1, {8'hFF, 8'h01, 8'hFF, 8'h80}, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, tk);
        #1 check("mask_z", z, 8'h81);
        drive(1'b1, {8'hFF, 8'h01, 8'hFF, 8'h80}, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, tk);
        #1 check("none_z", z, 8'h00); check("none_any", z_any, 1'b0);
        drive(1'b1, {8'hFF, 8'h01, 8'hFF, 8'h80}, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, tk);
        #1 check("none_inv_z", z, 8'hFF); check("none_inv_any", z_any, 1'b0);

        // 3-beat burst, inv toggled mid-burst
        drive(1'b1, {24'h0, 8'h01}, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, tk);
        drive(1'b1, {24'h0, 8'h10}, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, tk);
        #1 check("burst_quiet", out_valid, 1'b0);
        drive(1'b1, {24'h0, 8'h80}, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, tk);
        #1 check("burst_z", z, 8'h91); check("burst_b", beats, 3);

        // 20-beat burst saturates the beat count
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {24'h0, 8'(1 << (i % 8))}, 4'b0001,
                  (i == 0) ? 1'b0 : 1'($urandom), (i == 0) ? 1'b1 : 1'($urandom),
                  (i == 19), 1'b1, tk);
        end
        #1 check("sat_z", z, 8'hFF); check("sat_b", beats, CMAX);

        // back-pressure
        idle(1'b1);
        drive(1'b1, {24'h0, 8'h11}, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, tk);
        check("stall_b1", tk, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {24'h0, 8'h22}, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, tk);
            check("stall_hold_z", z, 8'h11);
            check("stall_block", tk, 1'b0);
        end
        drive(1'b1, {24'h0, 8'h22}, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, tk);
        check("rel_b2", tk, 1'b1);
        #1 check("rel_z2", z, 8'h22);
        drive(1'b1, {24'h0, 8'h33}, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, tk);
        check("rel_b3", tk, 1'b1);
        #1 check("rel_z3", z, 8'h33); check("rel_v3", out_valid, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // reset mid-burst
        drive(1'b1, {24'h0, 8'hF0}, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, tk);
        drive(1'b1, {24'h0, 8'h0A}, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, tk);
        #2 rstn = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1 check("mid_rst_valid", out_valid, 1'b0);
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        drive(1'b1, {24'h0, 8'h05}, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, tk);
        #1 check("post_rst_z", z, 8'h05); check("post_rst_b", beats, 1);
        idle(1'b1);

        // randomised traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 9) < 7), {$urandom}, 4'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 7), tk);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
